// File: rtl/tile_pkg.sv
// Shared definitions for the tile drain scheduler.
// Holds the buffer geometry parameters, the drain FSM state encoding and
// small helpers for packing/unpacking the {y,x} tile index and for
// saturating an occupancy count to the number of slots per tile.
package tile_pkg;

  localparam int NUM_TILES = 256;
  localparam int TILE_W    = 8;
  localparam int SLOTS     = 32;
  localparam int SLOT_W    = 5;
  localparam int CNT_W     = 6;
  localparam int POINT_W   = 32;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    OCC_REQ  = 4'd1,
    OCC_CHK  = 4'd2,
    PT_REQ   = 4'd3,
    PT_CAP   = 4'd4,
    OUT_HOLD = 4'd5,
    CLEAR    = 4'd6,
    NEXT     = 4'd7,
    DONE     = 4'd8
  } drain_state_t;

  // Tile index is {tile_y[3:0], tile_x[3:0]}.
  function automatic logic [TILE_W-1:0] tile_pack(input logic [3:0] y, input logic [3:0] x);
    return {y, x};
  endfunction

  function automatic logic [3:0] tile_y(input logic [TILE_W-1:0] t);
    return t[7:4];
  endfunction

  function automatic logic [3:0] tile_x(input logic [TILE_W-1:0] t);
    return t[3:0];
  endfunction

  // A corrupted occupancy above the slot count must not walk past slot 31.
  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] res;
    if (c > CNT_W'(SLOTS)) begin
      res = CNT_W'(SLOTS);
    end else begin
      res = c;
    end
    return res;
  endfunction

endpackage

// File: rtl/tile_drain_scheduler.sv
// Tile drain scheduler: once per frame walks tiles 0..255 of the LiDAR point
// buffer, reads each tile's occupancy, streams every stored point over a
// valid/ready port, clears drained tiles, and blocks tiler writes meanwhile.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   frame_start                 pulse to start a drain (ignored while busy)
//   occ_rd_en/occ_addr/occ_count  occupancy read (data one cycle after strobe)
//   pt_rd_en/pt_rd_tile/pt_rd_slot/pt_rd_data  point read (data one cycle later)
//   clear_en/clear_tile         one-cycle tile clear pulse
//   out_valid/out_ready/out_point/out_tile/out_last  point stream
//   wr_block, busy              high for the whole drain
//   frame_done                  one-cycle pulse at the end of the drain
module tile_drain_scheduler
  import tile_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  output logic               occ_rd_en,
  output logic [TILE_W-1:0]  occ_addr,
  input  logic [CNT_W-1:0]   occ_count,
  output logic               pt_rd_en,
  output logic [TILE_W-1:0]  pt_rd_tile,
  output logic [SLOT_W-1:0]  pt_rd_slot,
  input  logic [POINT_W-1:0] pt_rd_data,
  output logic               clear_en,
  output logic [TILE_W-1:0]  clear_tile,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [POINT_W-1:0] out_point,
  output logic [TILE_W-1:0]  out_tile,
  output logic               out_last,
  output logic               wr_block,
  output logic               busy,
  output logic               frame_done
);

  localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);

  drain_state_t        state_r;
  drain_state_t        state_s;
  logic [TILE_W-1:0]   tile_r;
  logic [SLOT_W-1:0]   slot_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                busy_r;

  // Addresses come straight from the walk registers; strobes qualify them.
  assign occ_addr   = tile_r;
  assign pt_rd_tile = tile_r;
  assign pt_rd_slot = slot_r;
  assign clear_tile = tile_r;
  assign wr_block   = busy_r;
  assign busy       = busy_r;

  // Next-state decode of the drain sequence
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (frame_start) begin
          state_s = OCC_REQ;
        end else begin
          state_s = IDLE;
        end
      end
      OCC_REQ: state_s = OCC_CHK;
      OCC_CHK: begin
        if (occ_count == {CNT_W{1'b0}}) begin
          state_s = NEXT;
        end else begin
          state_s = PT_REQ;
        end
      end
      PT_REQ: state_s = PT_CAP;
      PT_CAP: state_s = OUT_HOLD;
      OUT_HOLD: begin
        if (out_ready && out_last) begin
          state_s = CLEAR;
        end else if (out_ready) begin
          state_s = PT_REQ;
        end else begin
          state_s = OUT_HOLD;
        end
      end
      CLEAR: state_s = NEXT;
      NEXT: begin
        if (tile_r == LAST_TILE) begin
          state_s = DONE;
        end else begin
          state_s = OCC_REQ;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register and tile/slot walk with latched (saturated) point count
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      tile_r  <= {TILE_W{1'b0}};
      slot_r  <= {SLOT_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (frame_start) tile_r <= {TILE_W{1'b0}};
        end
        OCC_CHK: begin
          slot_r <= {SLOT_W{1'b0}};
          cnt_r  <= sat_count(occ_count);
        end
        OUT_HOLD: begin
          if (out_ready && !out_last) slot_r <= slot_r + SLOT_W'(1);
        end
        NEXT: begin
          // Stop at the last tile so the index never wraps mid-frame.
          if (tile_r != LAST_TILE) tile_r <= tile_r + TILE_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Strobes registered from the next state so they line up with the state
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_rd_en  <= 1'b0;
      pt_rd_en   <= 1'b0;
      clear_en   <= 1'b0;
      frame_done <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      occ_rd_en  <= (state_s == OCC_REQ);
      pt_rd_en   <= (state_s == PT_REQ);
      clear_en   <= (state_s == CLEAR);
      frame_done <= (state_s == DONE);
      busy_r     <= (state_s != IDLE);
    end
  end

  // One-entry output holding register for the point stream
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_point <= {POINT_W{1'b0}};
      out_tile  <= {TILE_W{1'b0}};
      out_last  <= 1'b0;
    end else if (state_r == PT_CAP) begin
      // cnt_r >= 1 here, so cnt_r - 1 cannot underflow.
      out_valid <= 1'b1;
      out_point <= pt_rd_data;
      out_tile  <= tile_r;
      out_last  <= ({1'b0, slot_r} == (cnt_r - CNT_W'(1)));
    end else if (state_r == OUT_HOLD && out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_tile_drain_scheduler.sv
// Directed bench for tile_drain_scheduler: one populated tile per frame,
// buffer reads modelled with one-cycle latency, expected values from the
// frame timing (3 cycles per empty tile, 3n+4 per tile with n points, +1 DONE).
module tb_tile_drain_scheduler;
  import tile_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               frame_start;
  logic               occ_rd_en;
  logic [TILE_W-1:0]  occ_addr;
  logic [CNT_W-1:0]   occ_count;
  logic               pt_rd_en;
  logic [TILE_W-1:0]  pt_rd_tile;
  logic [SLOT_W-1:0]  pt_rd_slot;
  logic [POINT_W-1:0] pt_rd_data;
  logic               clear_en;
  logic [TILE_W-1:0]  clear_tile;
  logic               out_valid;
  logic               out_ready;
  logic [POINT_W-1:0] out_point;
  logic [TILE_W-1:0]  out_tile;
  logic               out_last;
  logic               wr_block;
  logic               busy;
  logic               frame_done;

  logic [TILE_W-1:0]  cfg_tile;
  logic [CNT_W-1:0]   cfg_occ;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tile_drain_scheduler dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .occ_rd_en(occ_rd_en), .occ_addr(occ_addr), .occ_count(occ_count),
    .pt_rd_en(pt_rd_en), .pt_rd_tile(pt_rd_tile), .pt_rd_slot(pt_rd_slot),
    .pt_rd_data(pt_rd_data), .clear_en(clear_en), .clear_tile(clear_tile),
    .out_valid(out_valid), .out_ready(out_ready), .out_point(out_point),
    .out_tile(out_tile), .out_last(out_last), .wr_block(wr_block),
    .busy(busy), .frame_done(frame_done)
  );

  function automatic logic [POINT_W-1:0] point_of(input logic [TILE_W-1:0] t, input int s);
    logic [SLOT_W-1:0] sl;
    sl = SLOT_W'(s);
    return {t, 3'b101, sl, t ^ 8'h3C, 3'b010, sl};
  endfunction

  // Buffer model: registered reads, data valid the cycle after the strobe
  always @(posedge clk) begin
    occ_count  <= (occ_rd_en && occ_addr == cfg_tile) ? cfg_occ : 6'd0;
    pt_rd_data <= pt_rd_en ? point_of(pt_rd_tile, int'(pt_rd_slot)) : 32'hDEAD_0000;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [TILE_W-1:0] tile;
    logic [CNT_W-1:0]  occ;
    int                exp_pts;
    int                exp_cycles;
    int                stall_pt;
    int                stall_len;
    bit                mid_pulse;
  } vec_t;

  task automatic run_frame(input vec_t v);
    int cyc = 0, hs = 0, clears = 0, lasts = 0, bad = 0, rd_cnt = 0;
    int last_slot = -1, occ_reads = 0, first_occ = -1, done_at = 0;
    int stall_ctr = 0, unstable = 0, rd_in_valid = 0, busy_low = 0, post_bad = 0;
    logic [POINT_W-1:0] held = '0;
    cfg_tile = v.tile;
    cfg_occ  = v.occ;
    out_ready = 1'b1;
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    while (done_at == 0 && cyc < 3000) begin
      cyc++;
      if (!busy || !wr_block) busy_low++;
      if (occ_rd_en) begin
        if (first_occ < 0) first_occ = int'(occ_addr);
        occ_reads++;
      end
      if (pt_rd_en) begin
        rd_cnt++;
        last_slot = int'(pt_rd_slot);
        if (pt_rd_tile !== v.tile) bad++;
      end
      if (pt_rd_en && out_valid) rd_in_valid++;
      if (clear_en) begin
        clears++;
        if (clear_tile !== v.tile || hs != v.exp_pts) bad++;
      end
      if (frame_done) done_at = cyc;
      if (out_valid) begin
        if (hs == v.stall_pt && stall_ctr < v.stall_len) begin
          out_ready = 1'b0;
          if (stall_ctr == 0) held = out_point;
          else if (out_point !== held) unstable++;
          stall_ctr++;
        end else begin
          out_ready = 1'b1;
          if (out_point !== point_of(v.tile, hs) || out_tile !== v.tile ||
              out_last !== (hs == v.exp_pts - 1)) bad++;
          if (out_last) lasts++;
          hs++;
        end
      end else begin
        out_ready = 1'b1;
      end
      if (v.mid_pulse && cyc == 50) frame_start = 1'b1;
      if (cyc == 51) frame_start = 1'b0;
      if (done_at == 0) @(negedge clk);
    end
    @(negedge clk);
    check("busy_after_done", {busy, wr_block}, 2'b00);
    for (int i = 0; i < 6; i++) begin
      if (busy || frame_done || out_valid || occ_rd_en) post_bad++;
      @(negedge clk);
    end
    check("done_cycle", done_at, v.exp_cycles);
    check("points", hs, v.exp_pts);
    check("pt_reads", rd_cnt, v.exp_pts);
    check("clears", clears, (v.exp_pts > 0) ? 1 : 0);
    check("last_flags", lasts, (v.exp_pts > 0) ? 1 : 0);
    check("stream_data", bad, 0);
    check("occ_reads", occ_reads, NUM_TILES);
    check("first_occ_tile", first_occ, 0);
    check("busy_during_drain", busy_low, 0);
    check("no_restart", post_bad, 0);
    if (v.exp_pts > 0) check("last_slot", last_slot, v.exp_pts - 1);
    if (v.stall_len > 0) begin
      check("stall_cycles", stall_ctr, v.stall_len);
      check("stall_stable", unstable, 0);
      check("stall_no_read", rd_in_valid, 0);
    end
  endtask

  vec_t vecs[7];

  initial begin
    int waited;
    vecs[0] = '{8'h00,  6'd0, 0,  769, -1,  0, 1'b0};
    vecs[1] = '{8'h23,  6'd3, 3,  779, -1,  0, 1'b0};
    vecs[2] = '{8'hFF, 6'd32, 32, 866, -1,  0, 1'b0};
    vecs[3] = '{8'h05, 6'd40, 32, 866, -1,  0, 1'b0};
    vecs[4] = '{8'h23,  6'd3, 3,  789,  1, 10, 1'b1};
    vecs[5] = '{8'h80, 6'd31, 31, 863, -1,  0, 1'b0};
    vecs[6] = '{8'hF0,  6'd1, 1,  773, -1,  0, 1'b0};

    reset = 1'b1; frame_start = 1'b0; out_ready = 1'b1;
    cfg_tile = 8'h00; cfg_occ = 6'd0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {occ_rd_en, pt_rd_en, clear_en, out_valid, out_last, wr_block, busy, frame_done}, 8'h00);
    check("reset_data", {occ_addr, pt_rd_tile, pt_rd_slot, clear_tile, out_point, out_tile}, 69'h0);
    reset = 1'b0;

    // frame_start together with reset: reset wins
    @(negedge clk) begin reset = 1'b1; frame_start = 1'b1; end
    @(negedge clk) begin reset = 1'b0; frame_start = 1'b0; end
    check("reset_beats_start", {busy, occ_rd_en}, 2'b00);
    @(negedge clk);
    check("reset_beats_start_2", {busy, occ_rd_en}, 2'b00);

    for (int i = 0; i < 7; i++) run_frame(vecs[i]);

    // Reset while a point of tile 7 is held
    cfg_tile = 8'h07; cfg_occ = 6'd4; out_ready = 1'b0;
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    waited = 0;
    while (!out_valid && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("hold_reached", {out_valid, out_tile}, {1'b1, 8'h07});
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    out_ready = 1'b1;
    check("abort_ctrl", {occ_rd_en, pt_rd_en, clear_en, out_valid, out_last, wr_block, busy, frame_done}, 8'h00);
    check("abort_data", {occ_addr, pt_rd_tile, pt_rd_slot, clear_tile, out_point, out_tile}, 69'h0);
    waited = 0;
    for (int i = 0; i < 10; i++) begin
      if (clear_en || frame_done || busy) waited++;
      @(negedge clk);
    end
    check("abort_quiet", waited, 0);
    run_frame('{8'h07, 6'd4, 4, 782, -1, 0, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
